// File: rtl/amci_arbiter.sv
// Round-robin arbiter sharing one AMCI user port (write + read side) among NUM_CLIENTS requesters.
// Optional WAIT-state watchdog enabled by defining AMCI_ARB_TIMEOUT_EN.
module amci_arbiter #(
  parameter int unsigned NUM_CLIENTS    = 4,
  parameter int unsigned ADDR_WIDTH     = 32,
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic                              CLK,
  input  logic                              RESETN,
  input  logic [NUM_CLIENTS-1:0]            CLT_REQ,
  input  logic [NUM_CLIENTS-1:0]            CLT_RNW,
  input  logic [NUM_CLIENTS*ADDR_WIDTH-1:0] CLT_ADDR,
  input  logic [NUM_CLIENTS*DATA_WIDTH-1:0] CLT_WDATA,
  output logic [NUM_CLIENTS-1:0]            CLT_GNT,
  output logic [NUM_CLIENTS-1:0]            CLT_DONE,
  output logic [DATA_WIDTH-1:0]             CLT_RDATA,
  output logic                              CLT_ERR,
  output logic [ADDR_WIDTH-1:0]             AMCI_WADDR,
  output logic [DATA_WIDTH-1:0]             AMCI_WDATA,
  output logic                              AMCI_WRITE,
  input  logic                              AMCI_WIDLE,
  output logic [ADDR_WIDTH-1:0]             AMCI_RADDR,
  input  logic [DATA_WIDTH-1:0]             AMCI_RDATA,
  output logic                              AMCI_READ,
  input  logic                              AMCI_RIDLE
);

  localparam int unsigned PTR_W = $clog2(NUM_CLIENTS);

  if (NUM_CLIENTS < 2 || NUM_CLIENTS > 8 || TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_cfg_err
    $error("amci_arbiter: unsupported parameter set");
  end

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT} state_t;

  state_t                  state_q, state_d;
  logic [PTR_W-1:0]        ptr_q, ptr_d, winner_q, winner_d, pick, cand;
  logic                    rnw_q, rnw_d, found, side_idle;
  logic [NUM_CLIENTS-1:0]  gnt_q, gnt_d, done_q, done_d;
  logic [DATA_WIDTH-1:0]   rdata_q, rdata_d, wdata_q, wdata_d;
  logic [ADDR_WIDTH-1:0]   waddr_q, waddr_d, raddr_q, raddr_d;
  logic                    write_q, write_d, read_q, read_d;
  logic [ADDR_WIDTH-1:0]   addr_arr  [NUM_CLIENTS];
  logic [DATA_WIDTH-1:0]   wdata_arr [NUM_CLIENTS];

  for (genvar g = 0; g < NUM_CLIENTS; g++) begin : g_unpack
    assign addr_arr[g]  = CLT_ADDR[g*ADDR_WIDTH +: ADDR_WIDTH];
    assign wdata_arr[g] = CLT_WDATA[g*DATA_WIDTH +: DATA_WIDTH];
  end

  assign side_idle = rnw_q ? AMCI_RIDLE : AMCI_WIDLE;

`ifdef AMCI_ARB_TIMEOUT_EN
  localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT_CYCLES - 1);
  logic [15:0] cnt_q, cnt_d;
  logic        err_q, err_d;
  assign CLT_ERR = err_q;
`else
  assign CLT_ERR = 1'b0;
`endif

  // First requester at or after the round-robin pointer, wrapping past the last client.
  always_comb begin
    found = 1'b0;
    pick  = ptr_q;
    cand  = ptr_q;
    for (int unsigned k = 0; k < NUM_CLIENTS; k++) begin
      cand = PTR_W'((32'(ptr_q) + k) % NUM_CLIENTS);
      if (!found && CLT_REQ[cand]) begin
        found = 1'b1;
        pick  = cand;
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    winner_d = winner_q;
    rnw_d    = rnw_q;
    gnt_d    = '0;
    done_d   = '0;
    write_d  = 1'b0;
    read_d   = 1'b0;
    rdata_d  = rdata_q;
    waddr_d  = waddr_q;
    wdata_d  = wdata_q;
    raddr_d  = raddr_q;
`ifdef AMCI_ARB_TIMEOUT_EN
    err_d    = 1'b0;
    cnt_d    = cnt_q;
`endif
    unique case (state_q)
      S_IDLE: begin
        if (found && AMCI_WIDLE && AMCI_RIDLE) begin
          state_d  = S_ISSUE;
          winner_d = pick;
          rnw_d    = CLT_RNW[pick];
          gnt_d    = NUM_CLIENTS'(1) << pick;
          ptr_d    = (32'(pick) == NUM_CLIENTS - 1) ? '0 : pick + PTR_W'(1);
          if (CLT_RNW[pick]) begin
            read_d  = 1'b1;
            raddr_d = addr_arr[pick];
          end else begin
            write_d = 1'b1;
            waddr_d = addr_arr[pick];
            wdata_d = wdata_arr[pick];
          end
        end
      end
      // Master only sees the strobe now, so its idle flags are still stale here.
      S_ISSUE: begin
        state_d = S_WAIT;
`ifdef AMCI_ARB_TIMEOUT_EN
        cnt_d   = '0;
`endif
      end
      S_WAIT: begin
        if (side_idle) begin
          state_d = S_IDLE;
          done_d  = NUM_CLIENTS'(1) << winner_q;
          if (rnw_q) rdata_d = AMCI_RDATA;
        end
`ifdef AMCI_ARB_TIMEOUT_EN
        else if (cnt_q == TIMEOUT_LAST) begin
          state_d = S_IDLE;
          done_d  = NUM_CLIENTS'(1) << winner_q;
          err_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
`endif
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RESETN) begin
      state_q  <= S_IDLE;
      ptr_q    <= '0;
      winner_q <= '0;
      rnw_q    <= 1'b0;
      gnt_q    <= '0;
      done_q   <= '0;
      write_q  <= 1'b0;
      read_q   <= 1'b0;
      rdata_q  <= '0;
      waddr_q  <= '0;
      wdata_q  <= '0;
      raddr_q  <= '0;
`ifdef AMCI_ARB_TIMEOUT_EN
      err_q    <= 1'b0;
      cnt_q    <= '0;
`endif
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      winner_q <= winner_d;
      rnw_q    <= rnw_d;
      gnt_q    <= gnt_d;
      done_q   <= done_d;
      write_q  <= write_d;
      read_q   <= read_d;
      rdata_q  <= rdata_d;
      waddr_q  <= waddr_d;
      wdata_q  <= wdata_d;
      raddr_q  <= raddr_d;
`ifdef AMCI_ARB_TIMEOUT_EN
      err_q    <= err_d;
      cnt_q    <= cnt_d;
`endif
    end
  end

  assign CLT_GNT    = gnt_q;
  assign CLT_DONE   = done_q;
  assign CLT_RDATA  = rdata_q;
  assign AMCI_WADDR = waddr_q;
  assign AMCI_WDATA = wdata_q;
  assign AMCI_WRITE = write_q;
  assign AMCI_RADDR = raddr_q;
  assign AMCI_READ  = read_q;

endmodule
